fifo_push_adapter: RTL and testbench

FIFO_PUSH_ADAPTER -- requirements
Module: fifo_push_adapter

---
 rtl/fifo_push_adapter_pkg.sv | 18 +
 rtl/fifo_push_adapter_skid_buf2.sv | 61 ++++++
 rtl/fifo_push_adapter.sv | 155 +++++++++++++++
 tb/tb_fifo_push_adapter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_push_adapter_pkg.sv
// Shared types and constants for the packet-aware FIFO push adapter.
// Holds the FSM encoding, skid buffer depth and statistics counter width.
package fifo_push_adapter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CW    = $clog2(SKID_DEPTH + 1);
  localparam int STATS_W    = 16;

  typedef logic [SKID_CW-1:0] skid_cnt_t;
  typedef logic [STATS_W-1:0] stat_t;

endpackage

// File: rtl/fifo_push_adapter_skid_buf2.sv
// skid_buf2: 2-entry in-order buffer, head visible combinationally, 1-cycle write-to-head latency.
// A write into a full buffer is ignored unless a pop happens the same cycle; head holds when it drains.
module skid_buf2
  import fifo_push_adapter_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              wclk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              wr,
  input  logic              rd,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] head,
  output skid_cnt_t         count
);

  localparam skid_cnt_t FULL = skid_cnt_t'(SKID_DEPTH);

  logic [DWIDTH-1:0] ent0;
  logic [DWIDTH-1:0] ent1;
  logic              do_rd;
  logic              do_wr;

  assign do_rd = rd && (count != '0);
  assign do_wr = wr && ((count != FULL) || do_rd);
  assign head  = ent0;

  always_ff @(posedge wclk or negedge rstn) begin
    if (!rstn) begin
      ent0  <= '0;
      ent1  <= '0;
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      case ({do_wr, do_rd})
        2'b10: begin
          count <= count + 1'b1;
          if (count == '0) ent0 <= wdata;
          else             ent1 <= wdata;
        end
        2'b01: begin
          count <= count - 1'b1;
          // Last entry leaving: keep ent0 so the head output holds its value.
          if (count == FULL) ent0 <= ent1;
        end
        2'b11: begin
          if (count == FULL) begin
            ent0 <= ent1;
            ent1 <= wdata;
          end else begin
            ent0 <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_push_adapter.sv
// fifo_push_adapter: packet-aware skid stage feeding an async FIFO write port; optional stats via FIFO_PUSH_ADAPTER_STATS_EN.
// Accept-to-push latency 1 cycle; s_ready registered, drops with 2 beats buffered, held high while discarding.
module fifo_push_adapter
  import fifo_push_adapter_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic              wclk,
  input  logic              rstn,
  input  logic              soft_clr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWIDTH-1:0] s_data,
  input  logic              s_last,
  output logic              push,
  output logic [DWIDTH-1:0] din,
  input  logic              fifo_full,
  input  logic              overflow,
  output logic              pkt_err,
  output logic              ovf_err,
  output logic              busy
`ifdef FIFO_PUSH_ADAPTER_STATS_EN
  ,
  output logic [STATS_W-1:0] pkt_cnt,
  output logic [STATS_W-1:0] drop_cnt
`endif
);

  localparam int             BW       = $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0]  LAST_IDX = BW'(MAX_BEATS);
  localparam skid_cnt_t      BUF_FULL = skid_cnt_t'(SKID_DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic [BW-1:0]     beat_cnt;
  logic [BW-1:0]     beat_cnt_nxt;
  logic              accept;
  logic              buf_wr;
  logic              trunc;
  skid_cnt_t         buf_cnt;
  skid_cnt_t         buf_cnt_nxt;
  logic [DWIDTH-1:0] buf_head;

  assign accept = s_valid & s_ready;
  assign buf_wr = accept & (state != DROP) & ~soft_clr;
  assign push   = (buf_cnt != '0) & ~fifo_full;
  assign din    = buf_head;
  assign busy   = (state != IDLE) | (buf_cnt != '0);

  skid_buf2 #(
    .DWIDTH(DWIDTH)
  ) u_skid (
    .wclk  (wclk),
    .rstn  (rstn),
    .clr   (soft_clr),
    .wr    (buf_wr),
    .rd    (push),
    .wdata (s_data),
    .head  (buf_head),
    .count (buf_cnt)
  );

  always_comb begin
    buf_cnt_nxt = buf_cnt;
    if (buf_wr && !push)      buf_cnt_nxt = buf_cnt + 1'b1;
    else if (!buf_wr && push) buf_cnt_nxt = buf_cnt - 1'b1;
  end

  always_ff @(posedge wclk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    trunc        = 1'b0;
    if (accept) begin
      case (state)
        IDLE, PKT: begin
          if (s_last) begin
            state_nxt    = IDLE;
            beat_cnt_nxt = '0;
          end else if (beat_cnt + 1'b1 == LAST_IDX) begin
            // The limit beat itself is still written; only later beats are discarded.
            state_nxt    = DROP;
            beat_cnt_nxt = LAST_IDX;
            trunc        = 1'b1;
          end else begin
            state_nxt    = PKT;
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
        DROP: begin
          if (s_last) begin
            state_nxt    = IDLE;
            beat_cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt    = IDLE;
          beat_cnt_nxt = '0;
        end
      endcase
    end
    if (soft_clr) begin
      state_nxt    = IDLE;
      beat_cnt_nxt = '0;
      trunc        = 1'b0;
    end
  end

  always_ff @(posedge wclk or negedge rstn) begin
    if (!rstn) begin
      s_ready <= 1'b0;
      pkt_err <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      pkt_err <= trunc;
      if (soft_clr)      ovf_err <= 1'b0;
      else if (overflow) ovf_err <= 1'b1;
      if (soft_clr)               s_ready <= 1'b0;
      else if (state_nxt == DROP) s_ready <= 1'b1;
      else                        s_ready <= (buf_cnt_nxt < BUF_FULL);
    end
  end

`ifdef FIFO_PUSH_ADAPTER_STATS_EN
  logic pkt_done;
  logic drop_beat;

  assign pkt_done  = accept & s_last & ~soft_clr;
  assign drop_beat = accept & (state == DROP) & ~soft_clr;

  always_ff @(posedge wclk or negedge rstn) begin
    if (!rstn) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else if (soft_clr) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (pkt_done)  pkt_cnt  <= pkt_cnt + 1'b1;
      if (drop_beat) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_push_adapter.sv
// Bench for fifo_push_adapter: directed scenarios plus random traffic against a packet-level queue model.
module tb_fifo_push_adapter;

  localparam int DW = 8;
  localparam int MB = 16;

  logic          wclk = 1'b0;
  logic          rstn = 1'b1;
  logic          soft_clr = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          fifo_full = 1'b0;
  logic          overflow = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          push;
  logic          pkt_err;
  logic          ovf_err;
  logic          busy;
  logic [DW-1:0] din;
`ifdef FIFO_PUSH_ADAPTER_STATS_EN
  logic [15:0]   pkt_cnt;
  logic [15:0]   drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int stall_left = 0;

  always #5 wclk = ~wclk;

  fifo_push_adapter #(
    .DWIDTH    (DW),
    .MAX_BEATS (MB)
  ) dut (
    .wclk      (wclk),
    .rstn      (rstn),
    .soft_clr  (soft_clr),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .push      (push),
    .din       (din),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .pkt_err   (pkt_err),
    .ovf_err   (ovf_err),
    .busy      (busy)
`ifdef FIFO_PUSH_ADAPTER_STATS_EN
    ,
    .pkt_cnt   (pkt_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  // Packet-level model: pending beats, position in packet, discard mode.
  logic [DW-1:0] q[$];
  int            beat_idx;
  bit            dropping;
  bit            rdy_m;
  bit            perr_m;
  bit            ovf_m;
  int            pkts_m;
  int            drops_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    beat_idx = 0;
    dropping = 1'b0;
    rdy_m    = 1'b0;
    perr_m   = 1'b0;
    ovf_m    = 1'b0;
    pkts_m   = 0;
    drops_m  = 0;
  endtask

  task automatic check_outputs();
    bit exp_push;
    bit exp_busy;
    exp_push = (q.size() > 0) && !fifo_full;
    exp_busy = dropping || (beat_idx > 0) || (q.size() > 0);
    check_eq("s_ready", s_ready, rdy_m);
    check_eq("push", push, exp_push);
    if (exp_push) check_eq("din", din, q[0]);
    check_eq("busy", busy, exp_busy);
    check_eq("pkt_err", pkt_err, perr_m);
    check_eq("ovf_err", ovf_err, ovf_m);
`ifdef FIFO_PUSH_ADAPTER_STATS_EN
    check_eq("pkt_cnt", pkt_cnt, pkts_m & 32'hFFFF);
    check_eq("drop_cnt", drop_cnt, drops_m & 32'hFFFF);
`endif
  endtask

  // One clock cycle: drive, check at negedge, advance model at posedge.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit l,
                      input bit full, input bit ovf, input bit clr, output bit acc);
    bit wr;
    s_valid   = v;
    s_data    = d;
    s_last    = l;
    fifo_full = full;
    overflow  = ovf;
    soft_clr  = clr;
    @(negedge wclk);
    check_outputs();
    @(posedge wclk);
    wr  = (q.size() > 0) && !full;
    acc = v && rdy_m;
    if (wr) void'(q.pop_front());
    perr_m = 1'b0;
    if (clr) begin
      q.delete();
      beat_idx = 0;
      dropping = 1'b0;
      ovf_m    = 1'b0;
      pkts_m   = 0;
      drops_m  = 0;
      rdy_m    = 1'b0;
      acc      = 1'b0;
    end else begin
      if (ovf) ovf_m = 1'b1;
      if (acc) begin
        if (dropping) begin
          drops_m++;
          if (l) begin
            dropping = 1'b0;
            beat_idx = 0;
            pkts_m++;
          end
        end else begin
          q.push_back(d);
          beat_idx++;
          if (l) begin
            beat_idx = 0;
            pkts_m++;
          end else if (beat_idx == MB) begin
            dropping = 1'b1;
            perr_m   = 1'b1;
          end
        end
      end
      rdy_m = dropping || (q.size() < 2);
    end
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
  endtask

  task automatic send(input logic [DW-1:0] d, input bit l);
    bit acc;
    int tries;
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 64) begin
      step(1'b1, d, l, stall_left > 0, 1'b0, 1'b0, acc);
      if (stall_left > 0) stall_left--;
      tries++;
    end
    if (!acc) check_eq("send_timeout", acc, 1);
  endtask

  task automatic do_reset();
    s_valid   = 1'b0;
    s_last    = 1'b0;
    fifo_full = 1'b0;
    overflow  = 1'b0;
    soft_clr  = 1'b0;
    rstn      = 1'b0;
    #1;
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_push", push, 0);
    check_eq("rst_din", din, 0);
    check_eq("rst_pkt_err", pkt_err, 0);
    check_eq("rst_ovf_err", ovf_err, 0);
    check_eq("rst_busy", busy, 0);
`ifdef FIFO_PUSH_ADAPTER_STATS_EN
    check_eq("rst_pkt_cnt", pkt_cnt, 0);
    check_eq("rst_drop_cnt", drop_cnt, 0);
`endif
    model_reset();
    @(negedge wclk);
    @(negedge wclk);
    rstn = 1'b1;
    @(posedge wclk);
    rdy_m = 1'b1;
    #1;
  endtask

  initial begin
    bit acc;
    #2;
    do_reset();

    // 4-beat packet, FIFO never full
    for (int i = 1; i <= 4; i++) send(DW'(i), i == 4);
    idle(3);

    // FIFO full for 5 cycles mid-stream
    send(8'h10, 1'b0);
    send(8'h11, 1'b0);
    stall_left = 5;
    for (int i = 2; i < 8; i++) send(DW'(8'h10 + i), i == 7);
    idle(4);

    // 20-beat packet without early last: truncation after beat 16
    for (int i = 1; i <= 20; i++) send(DW'(8'h40 + i), i == 20);
    idle(4);

    // soft_clr with two beats parked behind a full FIFO
    stall_left = 20;
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    stall_left = 0;
    idle(2);
    send(8'h51, 1'b0);
    send(8'h52, 1'b1);
    idle(3);

    // overflow pulse is sticky until soft_clr
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    idle(4);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    idle(2);

    // reset mid-packet, then a single-beat packet
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b0);
    do_reset();
    send(8'hAA, 1'b1);
    idle(3);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(3, 0) != 0, DW'($urandom), $urandom_range(5, 0) == 0,
           $urandom_range(3, 0) == 0, $urandom_range(63, 0) == 0,
           $urandom_range(127, 0) == 0, acc);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
